// File: rtl/collision_pair_scanner.sv
// Per-frame collision pass: snapshots ball positions on start, walks every
// unordered pair (i<j) and hands each overlapping pair downstream over valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; last pass results held
// SCAN  | evaluating pair (idx_i, idx_j) against the snapshot
// EMIT  | presenting latched colliding pair until pair_ready
// DONE  | one-cycle end-of-pass pulse
module collision_pair_scanner #(
    parameter int NUM_BALLS  = 8,
    parameter int IDX_W      = 3,
    parameter int BALL_WIDTH = 19
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_BALLS*9-1:0] ball_x,
    input  logic [NUM_BALLS*8-1:0] ball_y,
    output logic                   busy,
    output logic                   done,
    output logic                   pair_valid,
    output logic [IDX_W-1:0]       pair_a,
    output logic [IDX_W-1:0]       pair_b,
    input  logic                   pair_ready,
    output logic [7:0]             collision_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BALLS - 2);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BALLS - 1);
    localparam logic [9:0]       THR_X  = 10'(BALL_WIDTH);
    localparam logic [8:0]       THR_Y  = 9'(BALL_WIDTH);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx_i;
    logic [IDX_W-1:0] idx_j;
    logic [8:0]       snap_x [NUM_BALLS];
    logic [7:0]       snap_y [NUM_BALLS];

    logic [8:0]       x_i, x_j;
    logic [7:0]       y_i, y_j;
    logic [9:0]       dx, adx;
    logic [8:0]       dy, ady;
    logic             hit;
    logic             last_pair;
    logic [IDX_W-1:0] nxt_i;
    logic [IDX_W-1:0] nxt_j;

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign pair_valid = (state == S_EMIT);

    // Zero-extend one bit before subtracting so the difference is a proper
    // signed value; the magnitude then fits in the same width.
    always_comb begin
        x_i = snap_x[idx_i];
        x_j = snap_x[idx_j];
        y_i = snap_y[idx_i];
        y_j = snap_y[idx_j];
        dx  = {1'b0, x_j} - {1'b0, x_i};
        dy  = {1'b0, y_j} - {1'b0, y_i};
        adx = dx[9] ? (10'd0 - dx) : dx;
        ady = dy[8] ? (9'd0 - dy) : dy;
        hit = (adx <= THR_X) && (ady <= THR_Y);
    end

    always_comb begin
        last_pair = (idx_i == LAST_I) && (idx_j == LAST_J);
        nxt_i     = idx_i;
        nxt_j     = idx_j + IDX_W'(1);
        if (idx_j == LAST_J) begin
            nxt_i = idx_i + IDX_W'(1);
            nxt_j = idx_i + IDX_W'(2);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            idx_i           <= '0;
            idx_j           <= '0;
            pair_a          <= '0;
            pair_b          <= '0;
            collision_count <= '0;
            for (int k = 0; k < NUM_BALLS; k++) begin
                snap_x[k] <= '0;
                snap_y[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_BALLS; k++) begin
                            snap_x[k] <= ball_x[k*9 +: 9];
                            snap_y[k] <= ball_y[k*8 +: 8];
                        end
                        idx_i           <= '0;
                        idx_j           <= IDX_W'(1);
                        collision_count <= '0;
                        state           <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        pair_a <= idx_i;
                        pair_b <= idx_j;
                        if (collision_count != 8'hFF)
                            collision_count <= collision_count + 8'd1;
                        state <= S_EMIT;
                    end else if (last_pair) begin
                        state <= S_DONE;
                    end else begin
                        idx_i <= nxt_i;
                        idx_j <= nxt_j;
                    end
                end
                S_EMIT: begin
                    // The pair indices stay put during EMIT so the advance
                    // happens from the pair just accepted.
                    if (pair_ready) begin
                        if (last_pair) begin
                            state <= S_DONE;
                        end else begin
                            idx_i <= nxt_i;
                            idx_j <= nxt_j;
                            state <= S_SCAN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/collision_pair_scanner.md
# collision_pair_scanner

Sequencer that sits directly upstream of the pairwise particle-overlap test and directly downstream of the position registers. On `start` it snapshots all particle positions, walks every unordered pair (i, j) with i < j, and applies the overlap rule to each pair. Each colliding pair is handed to the velocity-update stage over a valid/ready handshake. It is the per-frame collision pass of the gas simulator.

## Interface
- `NUM_BALLS`, 8, particle count (≥2)
- `IDX_W`, 3, index width, ≥ clog2(NUM_BALLS)
- `BALL_WIDTH`, 19, overlap threshold per axis in pixels (includes centre point)

- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  begin a pass; sampled only in IDLE
- `ball_x`  in  NUM_BALLS*9  packed x positions, ball k at [9k+8:9k], 0..319
- `ball_y`  in  NUM_BALLS*8  packed y positions, ball k at [8k+7:8k], 0..239
- `busy`  out  1  high from the cycle after start is accepted until DONE exits
- `done`  out  1  one-cycle pulse at end of pass
- `pair_valid`  out  1  colliding pair presented
- `pair_a`  out  IDX_W  lower index i
- `pair_b`  out  IDX_W  higher index j
- `pair_ready`  in  1  consumer accepts the pair this cycle
- `collision_count`  out  8  collisions found in the current/last pass, saturates at 255

## Operation
- States: IDLE, SCAN, EMIT, DONE.
- IDLE: `start`=1 → capture `ball_x`/`ball_y` into snapshot, set i=0, j=1, clear `collision_count`, go SCAN. The pass uses only the snapshot; input changes mid-pass have no effect.
- SCAN: evaluate pair (i, j) in one cycle.
  - Collision → latch `pair_a`=i and `pair_b`=j, increment count (saturating), go EMIT.
  - No collision → advance the pair; stay in SCAN or go DONE if it was the last pair.
- EMIT: `pair_valid`=1. `pair_a`/`pair_b` stay stable until `pair_ready`=1 in an EMIT cycle. Then advance the pair and go SCAN, or go DONE if it was the last pair.
- Pair advance: j+1 if j < NUM_BALLS-1; otherwise i+1 and j=i+2. The last pair is (NUM_BALLS-2, NUM_BALLS-1).
- Order: (0,1), (0,2) … (0,N-1), (1,2) … (N-2,N-1).
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Overlap rule:
  - Zero-extend x to 10 bits and y to 9 bits before subtracting, so the difference is signed two's complement.
  - dx = x_j − x_i and dy = y_j − y_i. Take absolute values at full width.
  - Collision iff |dx| ≤ BALL_WIDTH and |dy| ≤ BALL_WIDTH.
- `start` outside IDLE is ignored; it is not queued.
- `pair_ready` outside EMIT is ignored.
- Reset, including mid-pass or with a pair pending: all outputs go to 0, state goes to IDLE, and any pending pair is dropped. `collision_count` is 0 after reset.

## Timing
- Reset values: `busy`=0, `done`=0, `pair_valid`=0, `pair_a`=0, `pair_b`=0, `collision_count`=0.
- `start` is sampled at edge E0. SCAN occupies cycles from E1.
- With P = N(N−1)/2 pairs, C collisions, and S total cycles in which `pair_valid` is high with `pair_ready` low: `done` rises at edge E0 + P + C + S + 1.
  - N=8, no collisions: `done` at E29.
- Each EMIT lasts at least one cycle. `pair_ready` tied high gives exactly one extra cycle per collision.
- `collision_count` updates on the SCAN→EMIT edge. It is final when `done` is high and holds until the next accepted `start`.
- `busy` is low in IDLE and high in SCAN, EMIT and DONE.

## Test plan
- No collisions, `pair_ready`=1: x = 0, 40, …, 280; y = 0 for all balls; start → no `pair_valid`, `done` at E0+29, count 0, `busy` high from E1 through the DONE cycle.
- Positive-side threshold: ball0 (100,100), ball1 (119,119), others ≥40 px apart → one pair (0,1), count 1. Move ball1 to (120,119) → no pair.
- Negative-side threshold (sign handling): ball0 x=300, ball1 x=281, same y → pair (0,1). Then ball0 x=5, ball1 x=300 → no pair.
- Backpressure: single pair (2,5); hold `pair_ready` low for 5 EMIT cycles → `pair_valid`, `pair_a`=2, `pair_b`=5 stable throughout; `done` delayed exactly 5 cycles versus the ready-high run.
- All balls at (50,50), `pair_ready`=1 → 28 pairs in order (0,1) … (6,7), count 28, `done` at E0+57. Change the inputs mid-pass → output sequence unchanged.
- Control robustness:
  - `start` pulsed while `busy` → ignored.
  - `reset` while `pair_valid`=1 → same cycle all outputs 0, IDLE.
  - New `start` afterwards → fresh pass with count from 0.
